// File: rtl/sev_seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with hex decode, leading-zero
// blanking, per-digit decimal points and frame-synchronous double-buffered data.
module sev_seg_scan #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        sev_seg_scan_clk,
   input  logic        sev_seg_scan_rst,
   input  logic [31:0] sev_seg_scan_data,
   input  logic        sev_seg_scan_load,
   input  logic        sev_seg_scan_blank_lz,
   input  logic [7:0]  sev_seg_scan_dp_en,
   output logic [7:0]  sev_seg_scan_an,
   output logic [6:0]  sev_seg_scan_seg,
   output logic        sev_seg_scan_dp,
   output logic        sev_seg_scan_digit_tick
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] refresh_cnt;
   logic [2:0]    digit_idx;
   logic [2:0]    next_idx;
   logic [31:0]   active_data;
   logic [31:0]   pending_data;
   logic [31:0]   next_active;
   logic          pending_valid;
   logic          advance;
   logic          frame_wrap;
   logic [3:0]    cur_nibble;
   logic [31:0]   upper_mask;
   logic          blank_digit;
   logic [6:0]    hex_seg;
   logic [6:0]    seg_next;

   // Outputs are built from next-cycle index and data so the registered
   // display changes on the very edge the index advances or the frame swaps.
   always_comb begin
      advance     = (refresh_cnt == CNT_MAX);
      frame_wrap  = advance && (digit_idx == 3'd7);
      next_idx    = advance ? digit_idx + 3'd1 : digit_idx;
      next_active = active_data;
      if (frame_wrap) begin
         if (sev_seg_scan_load)
            next_active = sev_seg_scan_data;
         else if (pending_valid)
            next_active = pending_data;
      end
   end

   // Digit i is blanked when nibbles i..7 are all zero; digit 0 always shows.
   always_comb begin
      cur_nibble  = next_active[{next_idx, 2'b00} +: 4];
      upper_mask  = 32'hFFFF_FFFF << {next_idx, 2'b00};
      blank_digit = sev_seg_scan_blank_lz && (next_idx != 3'd0)
                    && ((next_active & upper_mask) == 32'h0);
      case (cur_nibble)
         4'h0:    hex_seg = 7'b1000000;
         4'h1:    hex_seg = 7'b1111001;
         4'h2:    hex_seg = 7'b0100100;
         4'h3:    hex_seg = 7'b0110000;
         4'h4:    hex_seg = 7'b0011001;
         4'h5:    hex_seg = 7'b0010010;
         4'h6:    hex_seg = 7'b0000010;
         4'h7:    hex_seg = 7'b1111000;
         4'h8:    hex_seg = 7'b0000000;
         4'h9:    hex_seg = 7'b0010000;
         4'hA:    hex_seg = 7'b0001000;
         4'hB:    hex_seg = 7'b0000011;
         4'hC:    hex_seg = 7'b1000110;
         4'hD:    hex_seg = 7'b0100001;
         4'hE:    hex_seg = 7'b0000110;
         default: hex_seg = 7'b0001110;
      endcase
      seg_next = blank_digit ? 7'b1111111 : hex_seg;
   end

   always_ff @(posedge sev_seg_scan_clk) begin
      if (sev_seg_scan_rst) begin
         refresh_cnt             <= '0;
         digit_idx               <= 3'd0;
         active_data             <= 32'h0;
         pending_data            <= 32'h0;
         pending_valid           <= 1'b0;
         sev_seg_scan_an         <= 8'b11111110;
         sev_seg_scan_seg        <= 7'b1000000;
         sev_seg_scan_dp         <= 1'b1;
         sev_seg_scan_digit_tick <= 1'b0;
      end else begin
         refresh_cnt             <= advance ? '0 : refresh_cnt + CW'(1);
         digit_idx               <= next_idx;
         active_data             <= next_active;
         sev_seg_scan_digit_tick <= advance;
         // A load coinciding with the frame wrap bypasses the pending buffer.
         if (sev_seg_scan_load && !frame_wrap) begin
            pending_data  <= sev_seg_scan_data;
            pending_valid <= 1'b1;
         end else if (frame_wrap) begin
            pending_valid <= 1'b0;
         end
         sev_seg_scan_an  <= ~(8'b00000001 << next_idx);
         sev_seg_scan_seg <= seg_next;
         sev_seg_scan_dp  <= ~sev_seg_scan_dp_en[next_idx];
      end
   end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed self-checking bench for sev_seg_scan with a 4-cycle digit slot,
// so one frame is 32 cycles; cyc counts rising edges since reset release.
module tb_sev_seg_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data;
   logic        load;
   logic        blank_lz;
   logic [7:0]  dp_en;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        digit_tick;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   sev_seg_scan #(.REFRESH_DIV(4)) dut (
      .sev_seg_scan_clk       (clk),
      .sev_seg_scan_rst       (rst),
      .sev_seg_scan_data      (data),
      .sev_seg_scan_load      (load),
      .sev_seg_scan_blank_lz  (blank_lz),
      .sev_seg_scan_dp_en     (dp_en),
      .sev_seg_scan_an        (an),
      .sev_seg_scan_seg       (seg),
      .sev_seg_scan_dp        (dp),
      .sev_seg_scan_digit_tick(digit_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic run_to(input int k);
      int guard = 0;
      while (cyc < k && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc < k) begin
         total++;
         bad++;
         $error("[TB] FAIL timeout: observed cyc=%0d expected cyc=%0d", cyc, k);
      end
   endtask

   task automatic apply_load(input logic [31:0] value);
      data = value;
      load = 1'b1;
   endtask

   initial begin
      rst      = 1'b1;
      blank_lz = 1'b0;
      dp_en    = 8'h00;
      apply_load(32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      check_val("rst_an", an, 8'b11111110);
      check_val("rst_seg", {1'b0, seg}, 8'b01000000);
      check_val("rst_dp", {7'b0, dp}, 8'd1);
      check_val("rst_tick", {7'b0, digit_tick}, 8'd0);
      load = 1'b0;
      rst  = 1'b0;

      // Refresh pacing: four cycles per digit, tick the cycle after each advance.
      for (int k = 1; k <= 3; k++) begin
         run_to(k);
         check_val("slot0_an", an, 8'b11111110);
      end
      run_to(2);
      check_val("mid_tick", {7'b0, digit_tick}, 8'd0);
      run_to(4);
      check_val("adv1_an", an, 8'b11111101);
      check_val("adv1_tick", {7'b0, digit_tick}, 8'd1);
      run_to(5);
      check_val("post_tick", {7'b0, digit_tick}, 8'd0);
      run_to(8);
      check_val("adv2_an", an, 8'b11111011);
      check_val("adv2_tick", {7'b0, digit_tick}, 8'd1);
      run_to(32);
      check_val("wrap_an", an, 8'b11111110);
      check_val("wrap_tick", {7'b0, digit_tick}, 8'd1);
      check_val("rst_load_discard", {1'b0, seg}, 8'b01000000);

      // Mid-frame load waits for the frame wrap.
      run_to(37);
      apply_load(32'h0000_00A5);
      run_to(38);
      load = 1'b0;
      check_val("midload_seg1", {1'b0, seg}, 8'b01000000);
      run_to(44);
      check_val("midload_seg3", {1'b0, seg}, 8'b01000000);
      run_to(64);
      check_val("a5_d0_an", an, 8'b11111110);
      check_val("a5_d0_seg", {1'b0, seg}, 8'b00010010);
      run_to(68);
      check_val("a5_d1_seg", {1'b0, seg}, 8'b00001000);
      run_to(72);
      check_val("a5_d2_seg", {1'b0, seg}, 8'b01000000);

      // Blanking takes effect on the next cycle, even within a digit slot.
      run_to(73);
      blank_lz = 1'b1;
      run_to(74);
      check_val("blank_d2_seg", {1'b0, seg}, 8'b01111111);
      run_to(92);
      check_val("blank_d7_seg", {1'b0, seg}, 8'b01111111);
      run_to(96);
      check_val("blank_d0_seg", {1'b0, seg}, 8'b00010010);
      run_to(100);
      check_val("blank_d1_seg", {1'b0, seg}, 8'b00001000);

      // Decimal point follows dp_en for the current digit, independent of blanking.
      run_to(101);
      dp_en = 8'h04;
      run_to(104);
      check_val("dp_d2_an", an, 8'b11111011);
      check_val("dp_d2_dp", {7'b0, dp}, 8'd0);
      check_val("dp_d2_seg", {1'b0, seg}, 8'b01111111);
      run_to(105);
      apply_load(32'h0000_0000);
      run_to(106);
      load = 1'b0;
      run_to(108);
      check_val("dp_d3_an", an, 8'b11110111);
      check_val("dp_d3_dp", {7'b0, dp}, 8'd1);
      run_to(128);
      check_val("zero_d0_seg", {1'b0, seg}, 8'b01000000);
      run_to(132);
      check_val("zero_d1_seg", {1'b0, seg}, 8'b01111111);
      run_to(133);
      blank_lz = 1'b0;

      // Load on the frame-wrap edge goes straight to the display.
      run_to(159);
      apply_load(32'h8765_4321);
      run_to(160);
      load = 1'b0;
      check_val("wrapload_d0_seg", {1'b0, seg}, 8'b01111001);
      check_val("wrapload_d0_dp", {7'b0, dp}, 8'd1);
      run_to(164);
      check_val("wrapload_d1_seg", {1'b0, seg}, 8'b00100100);
      run_to(168);
      check_val("wrapload_d2_seg", {1'b0, seg}, 8'b00110000);
      check_val("wrapload_d2_dp", {7'b0, dp}, 8'd0);
      run_to(188);
      check_val("wrapload_d7_seg", {1'b0, seg}, 8'b00000000);
      run_to(192);
      check_val("wrapload_hold_seg", {1'b0, seg}, 8'b01111001);

      // Second load in the same frame overwrites the first.
      run_to(193);
      apply_load(32'h1111_1111);
      run_to(194);
      load = 1'b0;
      run_to(202);
      check_val("twoload_mid_seg", {1'b0, seg}, 8'b00110000);
      apply_load(32'h2222_2222);
      run_to(203);
      load = 1'b0;
      run_to(224);
      check_val("twoload_d0_seg", {1'b0, seg}, 8'b00100100);
      run_to(252);
      check_val("twoload_d7_seg", {1'b0, seg}, 8'b00100100);

      // Reset mid-frame discards pending data.
      run_to(253);
      apply_load(32'h3333_3333);
      run_to(254);
      load = 1'b0;
      run_to(257);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst2_an", an, 8'b11111110);
      check_val("rst2_seg", {1'b0, seg}, 8'b01000000);
      check_val("rst2_dp", {7'b0, dp}, 8'd1);
      check_val("rst2_tick", {7'b0, digit_tick}, 8'd0);
      rst = 1'b0;
      run_to(32);
      check_val("rst2_wrap_an", an, 8'b11111110);
      check_val("rst2_wrap_seg", {1'b0, seg}, 8'b01000000);
      run_to(40);
      check_val("rst2_dp_an", an, 8'b11111011);
      check_val("rst2_dp_dp", {7'b0, dp}, 8'd0);
      run_to(44);
      check_val("rst2_dp3_dp", {7'b0, dp}, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sev_seg_scan.md
SEV_SEG_SCAN -- requirements
Module: sev_seg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the clock cycles per digit slot (legal range 2..2^20).
REQ-002 sev_seg_scan_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 sev_seg_scan_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 sev_seg_scan_data  input  32  SHALL carry eight 4-bit digit codes; nibble i drives digit i, digit 0 rightmost.
REQ-005 sev_seg_scan_load  input  1  SHALL be a one-cycle strobe that captures sev_seg_scan_data.
REQ-006 sev_seg_scan_blank_lz  input  1  SHALL enable leading-zero blanking when high.
REQ-007 sev_seg_scan_dp_en  input  8  SHALL enable the decimal point per digit (bit i = digit i).
REQ-008 sev_seg_scan_an  output  8  SHALL be the active-low anode enables, exactly one bit low at all times.
REQ-009 sev_seg_scan_seg  output  7  SHALL be the active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-010 sev_seg_scan_dp  output  1  SHALL be the active-low decimal point.
REQ-011 sev_seg_scan_digit_tick  output  1  SHALL pulse high for one cycle per digit advance.

Function
REQ-012 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap edge is the advance edge.
REQ-013 Digit index SHALL be 3 bits, increment by 1 on each advance edge, and wrap 7->0 (frame wrap).
REQ-014 an, seg and dp SHALL be registered and SHALL show the new digit on the same edge the index advances.
REQ-015 digit_tick SHALL be high in the cycle immediately following each advance edge, low otherwise.
REQ-016 A load SHALL write data into a pending register and set pending_valid; a later load before the frame wrap SHALL overwrite it.
REQ-017 On a frame wrap with pending_valid=1, pending SHALL move to the active register and pending_valid SHALL clear; the display never changes mid-frame.
REQ-018 If load and frame wrap coincide, the new data SHALL go straight to the active register and pending_valid SHALL clear.
REQ-019 Decode SHALL be full hex, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 With blank_lz=1, digit i (i>=1) SHALL be blanked (seg=1111111) when active nibbles i..7 are all zero; digit 0 is never blanked.
REQ-021 dp SHALL be 0 only when dp_en bit for the current index is 1; blanking does not affect dp.
REQ-022 blank_lz and dp_en SHALL be sampled every cycle (not latched by load).

Reset
REQ-023 On rst=1 at a clock edge: refresh counter=0, index=0, active=0, pending=0, pending_valid=0.
REQ-024 Reset output values SHALL be an=11111110, seg=1000000, dp=1, digit_tick=0.
REQ-025 rst SHALL take priority over load and advance; a load in the reset cycle SHALL be discarded.

Verification (REFRESH_DIV=4)
REQ-026 Release reset, data idle -> an=11111110 for 4 cycles, then 11111101; digit_tick once per 4 cycles; an=11111110 again after 32 cycles.
REQ-027 load 32'h000000A5 mid-frame -> digits unchanged until frame wrap; next frame digit0 seg=0010010, digit1 seg=0001000, digits 2-7 seg=1000000.
REQ-028 Same data, blank_lz=1 -> digits 2-7 seg=1111111, digits 0-1 unchanged; data 0 -> digit0 seg=1000000, digits 1-7 blank.
REQ-029 load 32'h87654321 on the frame-wrap edge -> frame starting that edge shows digit0 seg=1111001 ... digit7 seg=0000000; pending_valid=0.
REQ-030 Two loads (0x11111111 then 0x22222222) within one frame -> only 0x22222222 displayed after wrap.
REQ-031 rst mid-frame with pending_valid=1 -> next edge shows reset values; pending data never displayed; dp_en=8'h04 -> dp=0 only while an=11111011.
